// File: rtl/simon_io_pkg.sv
// rtl/simon_io_pkg.sv - Simon MMIO map, button event-word layout and helpers
package simon_io_pkg;

   localparam int BTN_ADDR    = 1000;
   localparam int RAND_ADDR   = 2000;
   localparam int TONE_ADDR   = 3000;

   localparam int NUM_BUTTONS = 4;
   localparam int DATA_W      = 32;
   localparam int CODE_LSB    = 0;
   localparam int VALID_BIT   = 4;
   localparam int OVF_BIT     = 5;

   typedef struct packed {
      logic                   ovf;
      logic                   valid;
      logic [NUM_BUTTONS-1:0] code;
   } evt_word_t;

   // Isolates the lowest set bit, so simultaneous presses resolve to the lowest index.
   function automatic logic [NUM_BUTTONS-1:0] lowest_onehot(input logic [NUM_BUTTONS-1:0] v);
      return v & (~v + 1'b1);
   endfunction

endpackage

// File: rtl/simon_button_capture_if.sv
// rtl/simon_button_capture_if.sv - CPU read port for the button event word
interface simon_button_capture_if;
   import simon_io_pkg::*;

   logic              rd_strobe;
   logic [DATA_W-1:0] rd_data;

   modport master (output rd_strobe, input rd_data);
   modport slave  (input rd_strobe, output rd_data);

endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchronizer plus stable-count debounce for one button
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             sync;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;

   assign sync = sync2_q ^ ACTIVE_LOW;

   // The flip lands on the edge that would make the count DEBOUNCE_CYCLES, so the counter never holds it.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign btn_level = level_q;

endmodule

// File: rtl/simon_button_capture.sv
// rtl/simon_button_capture.sv - debounced button press capture into a read-to-clear event word
module simon_button_capture
   import simon_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] btn_raw,
   simon_button_capture_if.slave  bus,
   output logic [NUM_BUTTONS-1:0] btn_level,
   output logic                   evt_pulse
);
   logic [NUM_BUTTONS-1:0] level_prev_q;
   logic [NUM_BUTTONS-1:0] press;
   logic                   any_press, multi_press;
   evt_word_t              evt_q, evt_d;
   logic                   pulse_q;

   for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_deb (
         .clock     (clock),
         .reset     (reset),
         .btn_raw   (btn_raw[b]),
         .btn_level (btn_level[b])
      );
   end

   assign press       = btn_level & ~level_prev_q;
   assign any_press   = |press;
   assign multi_press = |(press & (press - 1'b1));

   // A read in the press cycle consumes the old word, so the new press loads as if the register were empty.
   always_comb begin
      evt_d = evt_q;
      if (any_press) begin
         if (!evt_q.valid || bus.rd_strobe) begin
            evt_d.code  = lowest_onehot(press);
            evt_d.valid = 1'b1;
            evt_d.ovf   = multi_press;
         end else begin
            evt_d.ovf   = 1'b1;
         end
      end else if (bus.rd_strobe) begin
         evt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         level_prev_q <= '0;
         evt_q        <= '0;
         pulse_q      <= 1'b0;
      end else begin
         level_prev_q <= btn_level;
         evt_q        <= evt_d;
         pulse_q      <= any_press;
      end
   end

   always_comb begin
      bus.rd_data                           = '0;
      bus.rd_data[CODE_LSB +: NUM_BUTTONS]  = evt_q.code;
      bus.rd_data[VALID_BIT]                = evt_q.valid;
      bus.rd_data[OVF_BIT]                  = evt_q.ovf;
   end

   assign evt_pulse = pulse_q;

endmodule
